uart_boot_loader: RTL and testbench
===================================

// Module: uart_boot_loader
// PURPOSE
//  Boot sequencer between the UART byte receiver and the CPU core. After reset it
//  holds the CPU in reset and streams a length-prefixed program from UART into
//  instruction memory. It then releases the CPU and hands later UART bytes to the
//  CPU IN path through a one-byte holding register. It drives the 4 board LEDs
//  with the current state.
// PARAMETERS
//  INST_MEM_WIDTH  2   instruction memory address width; capacity = 2**INST_MEM_WIDTH words
// PORTS
//  CLK        in   1               system clock, all logic rising-edge
//  RST        in   1               asynchronous, active-high reset
//  rx_valid   in   1               1-cycle pulse: rx_data holds a received byte
//  rx_data    in   8               received byte
//  rx_err     in   1               1-cycle pulse: framing error on the current frame
//  imem_we    out  1               instruction memory write strobe (1 cycle)
//  imem_addr  out  INST_MEM_WIDTH  instruction memory word address
//  imem_wdata out  32              instruction word
//  cpu_rst    out  1               CPU reset; high until program load completes
//  in_valid   out  1               holding register full; byte offered to CPU IN
//  in_data    out  8               held byte
//  in_ready   in   1               CPU consumes the byte when in_valid & in_ready
//  overflow   out  1               sticky: a byte was dropped in RUN
//  led        out  4               one-hot state: [0]WAIT_LEN [1]LOAD [2]RUN [3]ERROR
// BEHAVIOUR
//  Reset values: state=WAIT_LEN, led=4'b0001, cpu_rst=1, imem_we=0, imem_addr=0,
//   imem_wdata=0, in_valid=0, in_data=0, overflow=0, byte_cnt=0, word_idx=0.
//  Byte assembly: big-endian, first byte is bits [31:24]; 2-bit byte_cnt wraps 3->0.
//  WAIT_LEN: 4 bytes form a 32-bit len.
//   - len==0: go to RUN.
//   - len > 2**INST_MEM_WIDTH: go to ERROR.
//   - otherwise: go to LOAD.
//   - The transition occurs on the edge after the 4th rx_valid.
//  LOAD: each 4-byte word is committed on the edge after its 4th rx_valid:
//   - imem_we=1 for exactly 1 cycle, imem_addr=word_idx, imem_wdata=word.
//   - word_idx then increments.
//   - After the write of word_idx==len-1, go to RUN; cpu_rst falls in the same
//     cycle that led shows RUN, one cycle after the final imem_we cycle.
//  RUN: cpu_rst=0 permanently until RST. Holding register:
//   - rx_valid while empty: in_valid=1 and in_data=rx_data on the next edge.
//   - in_valid & in_ready with no rx_valid: in_valid=0 next edge.
//   - rx_valid in the same cycle as a pop: load the new byte, in_valid stays 1
//     (no bubble).
//   - rx_valid while full and no pop: byte dropped, in_data unchanged,
//     overflow set (sticky until RST).
//   - rx_err in RUN: the frame is ignored; no state change, overflow unaffected.
//  ERROR: entered on rx_err in WAIT_LEN/LOAD or on an oversize len.
//   - cpu_rst stays 1, no further imem writes, all rx input ignored.
//   - Left only by RST.
//  rx_err and rx_valid in the same cycle: rx_err wins and the byte is discarded.
//  RST mid-operation: async return to the reset values; partial words and the
//   length are discarded; memory already written is not cleared.
//  Outputs are registered; led is a direct decode of the state register.
// TESTING
//  1 Assert RST, release -> led=0001, cpu_rst=1, imem_we=0, in_valid=0, overflow=0.
//  2 Bytes 00 00 00 02, 33 24 33 24, DE AD BE EF -> imem_we pulses twice
//    (addr0=0x33243324, addr1=0xDEADBEEF), then led=0100, cpu_rst=0.
//  3 Bytes 00 00 00 00 -> no imem_we; RUN one edge after the 4th byte.
//  4 With INST_MEM_WIDTH=2, bytes 00 00 00 05 -> led=1000, cpu_rst=1, no writes;
//    later bytes are ignored.
//  5 In RUN, in_ready=0: send A5 then 5A -> in_data=A5, overflow=1. Raise in_ready
//    for 1 cycle -> in_valid=0. Then send 3C together with a pop -> in_data=3C and
//    in_valid stays 1.
//  6 After 00 00 00 01, 12 34: pulse RST, then reload 00 00 00 01, CA FE BA BE ->
//    single write addr0=0xCAFEBABE; the partial 12 34 is never written.

Source files
------------

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: holds the CPU in reset while a length-prefixed program streams from UART
// into instruction memory, then forwards later UART bytes to the CPU through a one-byte holding register.
module uart_boot_loader #(
    parameter int INST_MEM_WIDTH = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    input  logic                      rx_err,
    output logic                      imem_we,
    output logic [INST_MEM_WIDTH-1:0] imem_addr,
    output logic [31:0]               imem_wdata,
    output logic                      cpu_rst,
    output logic                      in_valid,
    output logic [7:0]                in_data,
    input  logic                      in_ready,
    output logic                      overflow,
    output logic [3:0]                led
);
    localparam int IW = INST_MEM_WIDTH;
    localparam logic [31:0] CAP = 32'd1 << IW;

    typedef enum logic [1:0] {WAIT_LEN, LOAD, RUN, ERROR} state_t;

    state_t          state_q, state_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [23:0]     shift_q, shift_d;
    logic [IW:0]     len_q, len_d, word_idx_q, word_idx_d;
    logic            imem_we_q, imem_we_d;
    logic [IW-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]     imem_wdata_q, imem_wdata_d;
    logic            in_valid_q, in_valid_d;
    logic [7:0]      in_data_q, in_data_d;
    logic            overflow_q, overflow_d;
    logic            byte_ok, word_done, load_done, pop;
    logic [31:0]     word;

    assign byte_ok   = rx_valid & ~rx_err;
    assign word      = {shift_q, rx_data};
    assign word_done = byte_ok & (byte_cnt_q == 2'd3);
    // word_idx has already advanced past the final word while its write strobe is high
    assign load_done = imem_we_q & (word_idx_q == len_q);
    assign pop       = in_valid_q & in_ready;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        len_d        = len_q;
        word_idx_d   = word_idx_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        in_valid_d   = in_valid_q;
        in_data_d    = in_data_q;
        overflow_d   = overflow_q;
        case (state_q)
            WAIT_LEN: begin
                if (rx_err) state_d = ERROR;
                else if (byte_ok) begin
                    shift_d    = word[23:0];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (word_done) begin
                        len_d   = word[IW:0];
                        state_d = (word == 32'd0) ? RUN : (word > CAP) ? ERROR : LOAD;
                    end
                end
            end
            LOAD: begin
                if (rx_err) state_d = ERROR;
                else if (load_done) state_d = RUN;
                else if (byte_ok) begin
                    shift_d    = word[23:0];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (word_done) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_idx_q[IW-1:0];
                        imem_wdata_d = word;
                        word_idx_d   = word_idx_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (byte_ok && (!in_valid_q || pop)) begin
                    in_valid_d = 1'b1;
                    in_data_d  = rx_data;
                end else begin
                    in_valid_d = pop ? 1'b0 : in_valid_q;
                    overflow_d = overflow_q | byte_ok;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= WAIT_LEN;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            len_q        <= '0;
            word_idx_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            in_valid_q   <= 1'b0;
            in_data_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            in_valid_q   <= in_valid_d;
            in_data_q    <= in_data_d;
            overflow_q   <= overflow_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign in_valid   = in_valid_q;
    assign in_data    = in_data_q;
    assign overflow   = overflow_q;
    assign cpu_rst    = (state_q != RUN);
    assign led        = 4'b0001 << state_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: randomized program loads and RUN-mode byte traffic checked against a queue-based model.
module tb_uart_boot_loader;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_err = 1'b0;
    logic        in_ready = 1'b0;
    logic        imem_we, cpu_rst, in_valid, overflow;
    logic [1:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [7:0]  in_data;
    logic [3:0]  led;

    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0]  wa[$];
    logic [31:0] wd[$];
    logic [31:0] prog[4];

    uart_boot_loader #(.INST_MEM_WIDTH(2)) dut (
        .CLK(CLK), .RST(RST), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst(cpu_rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .overflow(overflow), .led(led)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (!RST && imem_we) begin
        wa.push_back(imem_addr);
        wd.push_back(imem_wdata);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        tick();
        wa.delete();
        wd.delete();
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) tick();
        send(b);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_gap(w[i*8 +: 8]);
    endtask

    task automatic chk_writes(input string tag, input int n);
        chk({tag, "_nwr"}, wa.size(), n);
        for (int i = 0; i < n && i < wa.size(); i++) begin
            chk({tag, "_addr"}, wa[i], i);
            chk({tag, "_data"}, wd[i], prog[i]);
        end
        wa.delete();
        wd.delete();
    endtask

    initial begin
        logic [7:0]  hq[$];
        logic        ovf;
        logic        pop;
        int          len;
        logic [31:0] big;

        // reset state
        do_reset();
        chk("rst_led", led, 4'b0001);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_we", imem_we, 0);
        chk("rst_in_valid", in_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_in_data", in_data, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);

        // two-word load with exact handover timing
        prog[0] = 32'h33243324;
        prog[1] = 32'hDEADBEEF;
        send_word(32'd2);
        chk("t2_led_load", led, 4'b0010);
        send_word(prog[0]);
        for (int i = 3; i >= 0; i--) send(prog[1][i*8 +: 8]);
        chk("t2_we_last", imem_we, 1);
        chk("t2_led_during_we", led, 4'b0010);
        chk("t2_cpu_rst_during_we", cpu_rst, 1);
        tick();
        chk("t2_led_run", led, 4'b0100);
        chk("t2_cpu_rst", cpu_rst, 0);
        chk("t2_we_off", imem_we, 0);
        chk_writes("t2", 2);

        // zero length: RUN on the edge after the 4th byte
        do_reset();
        send_word(32'd0);
        chk("t3_led", led, 4'b0100);
        chk("t3_cpu_rst", cpu_rst, 0);
        chk("t3_nwr", wa.size(), 0);

        // oversize lengths, later bytes ignored
        for (int it = 0; it < 3; it++) begin
            do_reset();
            big = (it == 0) ? 32'd5 : $urandom_range(6, 32'h7FFFFFFF);
            send_word(big);
            chk("t4_led", led, 4'b1000);
            chk("t4_cpu_rst", cpu_rst, 1);
            for (int i = 0; i < 8; i++) send_gap($urandom);
            tick();
            chk("t4_led_after", led, 4'b1000);
            chk("t4_nwr", wa.size(), 0);
            chk("t4_in_valid", in_valid, 0);
        end

        // rx_err during LOAD (with a simultaneous byte) and during WAIT_LEN
        do_reset();
        send_word(32'd2);
        send_gap(8'h11);
        rx_err = 1'b1;
        send(8'h22);
        rx_err = 1'b0;
        chk("err_load_led", led, 4'b1000);
        for (int i = 0; i < 10; i++) send_gap($urandom);
        chk("err_load_nwr", wa.size(), 0);
        chk("err_load_cpu_rst", cpu_rst, 1);
        do_reset();
        send_gap(8'h00);
        rx_err = 1'b1;
        tick();
        rx_err = 1'b0;
        chk("err_wait_led", led, 4'b1000);

        // randomized loads
        for (int it = 0; it < 6; it++) begin
            do_reset();
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) prog[i] = $urandom;
            send_word(len);
            for (int i = 0; i < len; i++) send_word(prog[i]);
            tick();
            tick();
            chk("rnd_led", led, 4'b0100);
            chk("rnd_cpu_rst", cpu_rst, 0);
            chk_writes("rnd", len);
        end

        // holding register directed
        do_reset();
        send_word(32'd0);
        send(8'hA5);
        send(8'h5A);
        chk("t5_in_data", in_data, 8'hA5);
        chk("t5_in_valid", in_valid, 1);
        chk("t5_overflow", overflow, 1);
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        chk("t5_pop", in_valid, 0);
        send(8'h11);
        chk("t5_refill", in_data, 8'h11);
        in_ready = 1'b1;
        send(8'h3C);
        in_ready = 1'b0;
        chk("t5_nobubble_valid", in_valid, 1);
        chk("t5_nobubble_data", in_data, 8'h3C);
        chk("t5_overflow_sticky", overflow, 1);

        // partial load discarded by reset, then clean reload
        do_reset();
        send_word(32'd1);
        send_gap(8'h12);
        send_gap(8'h34);
        chk("t6_nwr_partial", wa.size(), 0);
        do_reset();
        prog[0] = 32'hCAFEBABE;
        send_word(32'd1);
        send_word(prog[0]);
        tick();
        tick();
        chk_writes("t6", 1);
        chk("t6_led", led, 4'b0100);

        // randomized RUN traffic against a one-entry queue model
        do_reset();
        send_word(32'd0);
        hq.delete();
        ovf = 1'b0;
        for (int c = 0; c < 400; c++) begin
            chk("run_in_valid", in_valid, hq.size() != 0);
            if (hq.size() != 0) chk("run_in_data", in_data, hq[0]);
            chk("run_overflow", overflow, ovf);
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_err   = ($urandom_range(0, 7) == 0);
            rx_data  = $urandom;
            in_ready = $urandom_range(0, 1);
            pop = (hq.size() != 0) && in_ready;
            if (pop) void'(hq.pop_front());
            if (rx_valid && !rx_err) begin
                if (hq.size() == 0) hq.push_back(rx_data);
                else ovf = 1'b1;
            end
            tick();
        end
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        in_ready = 1'b0;
        chk("run_cpu_rst", cpu_rst, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
